// File: rtl/delay_pkg.sv
// Shared types and sizing helpers for the delay sequencer and its entry FIFO.
package delay_pkg;

   typedef enum logic [0:0] {StIdle, StActive} seq_state_e;

   function automatic int unsigned counts_per_unit(input int unsigned clk_mhz,
                                                   input int unsigned unit_us);
      return clk_mhz * unit_us;
   endfunction

   // Entry layout: {mark, delay[width-1:0]}, mark sits in the MSB.
   function automatic int unsigned entry_width(input int unsigned width);
      return width + 1;
   endfunction

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned presc_width(input int unsigned cpu);
      return (cpu > 1) ? $clog2(cpu) : 1;
   endfunction

endpackage

// File: rtl/delay_sequencer_if.sv
// Push handshake, control and status bundle of the delay sequencer.
interface delay_sequencer_if
   import delay_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
);
   logic                            enable_in;
   logic                            flush_in;
   logic [WIDTH-1:0]                delay_in;
   logic                            mark_in;
   logic                            delay_valid_in;
   logic                            delay_ready_out;
   logic [level_width(DEPTH)-1:0]   level_out;
   logic                            busy_out;
   logic                            mark_out;
   logic                            done_out;

   modport master (
      output enable_in, flush_in, delay_in, mark_in, delay_valid_in,
      input  delay_ready_out, level_out, busy_out, mark_out, done_out
   );

   modport slave (
      input  enable_in, flush_in, delay_in, mark_in, delay_valid_in,
      output delay_ready_out, level_out, busy_out, mark_out, done_out
   );
endinterface

// File: rtl/delay_fifo.sv
// Synchronous entry FIFO with level/full/empty, async reset and sync flush.
module delay_fifo
   import delay_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                          clock_in,
   input  logic                          reset_in,
   input  logic                          flush,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         pop_data,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          full,
   output logic                          empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = level_width(DEPTH);

   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      level_q <= level_q + LW'(1);
         else if (do_pop && !do_push) level_q <= level_q - LW'(1);
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clock_in) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign level    = level_q;
   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
endmodule

// File: rtl/delay_sequencer.sv
// Queued delay player: FIFO of (delay, mark) entries replayed back to back.
module delay_sequencer
   import delay_pkg::*;
#(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned UNIT_COUNTS_US = 10,
   parameter int unsigned CLK_MHZ        = 8,
   parameter int unsigned DEPTH          = 4
) (
   input logic               clock_in,
   input logic               reset_in,
   delay_sequencer_if.slave  bus
);
   localparam int unsigned CPU = counts_per_unit(CLK_MHZ, UNIT_COUNTS_US);
   localparam int unsigned PW  = presc_width(CPU);
   localparam int unsigned EW  = entry_width(WIDTH);
   localparam int unsigned LW  = level_width(DEPTH);
   localparam logic [PW-1:0] PRESC_RELOAD = PW'(CPU - 1);

   seq_state_e       state_q;
   logic [WIDTH-1:0] units_q;
   logic [PW-1:0]    presc_q;
   logic             busy_q, mark_q, done_q;

   logic [EW-1:0]    head;
   logic [LW-1:0]    fifo_level;
   logic             fifo_full, fifo_empty;
   logic             fifo_push, fifo_pop, complete;

   // Zero-delay entries complete the handshake but never enter the FIFO.
   assign fifo_push = bus.delay_valid_in && !fifo_full && !bus.flush_in &&
                      (bus.delay_in != '0);
   assign complete  = (state_q == StActive) && bus.enable_in &&
                      (units_q == WIDTH'(1)) && (presc_q == '0);
   assign fifo_pop  = bus.enable_in && !fifo_empty && !bus.flush_in &&
                      ((state_q == StIdle) || complete);

   delay_fifo #(
      .DATA_WIDTH (EW),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .flush     (bus.flush_in),
      .push      (fifo_push),
      .push_data ({bus.mark_in, bus.delay_in}),
      .pop       (fifo_pop),
      .pop_data  (head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= StIdle;
         units_q <= '0;
         presc_q <= '0;
         busy_q  <= 1'b0;
         mark_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.flush_in) begin
         state_q <= StIdle;
         units_q <= '0;
         presc_q <= '0;
         busy_q  <= 1'b0;
         mark_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= complete;
         // A pop covers both the idle start and the seamless follow-on load.
         if (fifo_pop) begin
            state_q <= StActive;
            units_q <= head[WIDTH-1:0];
            presc_q <= PRESC_RELOAD;
            busy_q  <= 1'b1;
            mark_q  <= head[WIDTH];
         end else if ((state_q == StActive) && bus.enable_in) begin
            if (complete) begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               mark_q  <= 1'b0;
            end else if (presc_q == '0) begin
               units_q <= units_q - WIDTH'(1);
               presc_q <= PRESC_RELOAD;
            end else begin
               presc_q <= presc_q - PW'(1);
            end
         end
      end
   end

   assign bus.delay_ready_out = !fifo_full;
   assign bus.level_out       = fifo_level;
   assign bus.busy_out        = busy_q;
   assign bus.mark_out        = mark_q;
   assign bus.done_out        = done_q;
endmodule
